pipelined_cla_adder: RTL

Parametrised, pipelined carry-lookahead adder/subtractor with valid/ready handshake. It is the next generation of the team's fixed 16-bit combinational CLA adder. The operand word is split into PIPE_STAGES slices. Each slice is built from 4-bit CLA groups, and the inter-slice carry is registered, so throughput is one operation per clock. It feeds the matrix-multiplier accumulate path and must tolerate downstream stalls.

---
 rtl/pipelined_cla_adder.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor with a valid/ready handshake.
// The word is cut into PIPE_STAGES slices. Each slice is a two-level CLA
// (4-bit groups plus group lookahead), and the carry between slices is
// registered. A single global advance enable moves the whole pipeline,
// so a stalled output freezes every stage in place.

// One slice: bit G/P, 4-bit group G/P, flat lookahead for the group carries,
// then flat lookahead inside each group. No carry ripples between groups.
module cla_slice #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         cmsb
);
    localparam int NG = W / 4;

    logic [W-1:0]  g, p;
    logic [NG-1:0] gg, gp;
    logic [NG:0]   gc;
    logic [W:0]    c;

    // Bit and group generate/propagate, then both lookahead levels.
    always_comb begin
        logic term;
        g  = a & b;
        p  = a ^ b;
        gg = '0;
        gp = '0;
        gc = '0;
        c  = '0;
        for (int j = 0; j < NG; j++) begin
            gg[j] = g[4*j+3]
                  | (p[4*j+3] & g[4*j+2])
                  | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                  | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
            gp[j] = &p[4*j +: 4];
        end
        // Group carries: each one is a sum of products over all lower groups.
        for (int j = 0; j <= NG; j++) begin
            gc[j] = cin;
            for (int m = 0; m < j; m++) gc[j] = gc[j] & gp[m];
            for (int i = 0; i < j; i++) begin
                term = gg[i];
                for (int m = i + 1; m < j; m++) term = term & gp[m];
                gc[j] = gc[j] | term;
            end
        end
        // Bit carries inside each group, seeded by that group's carry-in.
        for (int j = 0; j < NG; j++) begin
            for (int k = 0; k < 4; k++) begin
                c[4*j+k] = gc[j];
                for (int m = 0; m < k; m++) c[4*j+k] = c[4*j+k] & p[4*j+m];
                for (int i = 0; i < k; i++) begin
                    term = g[4*j+i];
                    for (int m = i + 1; m < k; m++) term = term & p[4*j+m];
                    c[4*j+k] = c[4*j+k] | term;
                end
            end
        end
        c[W] = gc[NG];
    end

    assign sum  = p ^ c[W-1:0];
    assign cout = c[W];
    assign cmsb = c[W-1];
endmodule

module pipelined_cla_adder #(
    parameter int DATA_WIDTH  = 16,
    parameter int PIPE_STAGES = 2,
    parameter int GROUP_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] inData_A,
    input  logic [DATA_WIDTH-1:0] inData_B,
    input  logic                  cin,
    input  logic                  sub,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] outData,
    output logic                  cout,
    output logic                  overflow
);
    localparam int SLICE = DATA_WIDTH / PIPE_STAGES;

    if (GROUP_WIDTH != 4) begin : g_bad_group
        $error("GROUP_WIDTH must be 4");
    end
    if ((PIPE_STAGES < 1) || (DATA_WIDTH % (4 * PIPE_STAGES) != 0)) begin : g_bad_split
        $error("DATA_WIDTH must be a multiple of 4*PIPE_STAGES");
    end

    logic                                  adv;
    logic [DATA_WIDTH-1:0]                 b_eff;
    logic                                  carry0;
    logic [PIPE_STAGES-1:0]                vld_pipe, c_q;
    logic [PIPE_STAGES-1:0][DATA_WIDTH-1:0] a_q, b_q, r_q;
    logic                                  ovf_q;

    // Subtract is A + ~B + 1; cin is ignored in that mode.
    assign b_eff  = sub ? ~inData_B : inData_B;
    assign carry0 = sub | cin;
    assign adv    = !out_valid || out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < PIPE_STAGES; k++) begin : g_stage
        logic [DATA_WIDTH-1:0] a_in, b_in, r_in, r_nxt, a_r, b_r, r_r;
        logic                  c_in, v_in, v_r, c_r;
        logic [SLICE-1:0]      s;
        logic                  co, cm;

        if (k == 0) begin : g_head
            assign a_in = inData_A;
            assign b_in = b_eff;
            assign c_in = carry0;
            assign v_in = in_valid;
            assign r_in = '0;
        end else begin : g_body
            assign a_in = a_q[k-1];
            assign b_in = b_q[k-1];
            assign c_in = c_q[k-1];
            assign v_in = vld_pipe[k-1];
            assign r_in = r_q[k-1];
        end

        cla_slice #(.W(SLICE)) u_slice (
            .a    (a_in[k*SLICE +: SLICE]),
            .b    (b_in[k*SLICE +: SLICE]),
            .cin  (c_in),
            .sum  (s),
            .cout (co),
            .cmsb (cm)
        );

        // Lower result slices ride along; this stage fills in its own slice.
        always_comb begin
            r_nxt = r_in;
            r_nxt[k*SLICE +: SLICE] = s;
        end

        // Stage register: loads from predecessor on advance, else holds.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_r <= 1'b0;
                c_r <= 1'b0;
                a_r <= '0;
                b_r <= '0;
                r_r <= '0;
            end else if (adv) begin
                v_r <= v_in;
                c_r <= co;
                a_r <= a_in;
                b_r <= b_in;
                r_r <= r_nxt;
            end
        end

        assign vld_pipe[k] = v_r;
        assign c_q[k]      = c_r;
        assign a_q[k]      = a_r;
        assign b_q[k]      = b_r;
        assign r_q[k]      = r_r;

        if (k == PIPE_STAGES - 1) begin : g_tail
            // Signed overflow: carry into MSB differs from carry out of MSB.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)   ovf_q <= 1'b0;
                else if (adv) ovf_q <= cm ^ co;
            end
        end
    end

    assign out_valid = vld_pipe[PIPE_STAGES-1];
    assign outData   = r_q[PIPE_STAGES-1];
    assign cout      = c_q[PIPE_STAGES-1];
    assign overflow  = ovf_q;
endmodule
